// File: rtl/music_pkg.sv
// Shared types and field widths for the note record/playback path.
package music_pkg;

    localparam int unsigned NOTE_W = 4;
    localparam int unsigned OCT_W  = 2;

    typedef enum logic [2:0] {
        StIdle,
        StRec,
        StLoad,
        StSound,
        StGap
    } state_t;

    // Width of one buffer entry: {note, octave, duration}.
    function automatic int unsigned entry_width(input int unsigned dur_w);
        return NOTE_W + OCT_W + dur_w;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..TICK_DIV-1 counter with synchronous clear and a one-cycle tick.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    // tick must not depend on clear: the FSM derives clear from tick.
    assign tick = (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Records live key presses (note, octave, held ticks) and replays them with recorded timing;
// live notes pass through to the tone path whenever playback is not running.
module note_sequencer
    import music_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned DUR_W     = 16,
    parameter int unsigned TICK_DIV  = 500000,
    parameter int unsigned GAP_TICKS = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NOTE_W-1:0]         note_in,
    input  logic [OCT_W-1:0]          octave_in,
    input  logic                      key_down,
    input  logic                      record_en,
    input  logic                      play_start,
    input  logic                      play_stop,
    input  logic                      clear,
    output logic [NOTE_W-1:0]         note_out,
    output logic [OCT_W-1:0]          octave_out,
    output logic                      sound_on,
    output logic                      busy,
    output logic [$clog2(DEPTH):0]    count,
    output logic [$clog2(DEPTH)-1:0]  play_index,
    output logic                      full,
    output logic                      done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = entry_width(DUR_W);

    state_t            state;
    logic              key_q;
    logic [NOTE_W-1:0] rec_note;
    logic [OCT_W-1:0]  rec_oct;
    // Counts up while recording, counts down remaining ticks in SOUND and GAP.
    logic [DUR_W-1:0]  dur;

    logic [EW-1:0]     mem [DEPTH];
    logic [EW-1:0]     rd_q;
    logic [EW-1:0]     wr_entry;
    logic [AW-1:0]     rd_addr;

    logic key_rise, key_fall, tick, state_chg, last;
    logic go_clear, go_load, go_rec, rec_end, stop, sound_end, gap_end;

    assign key_rise = key_down & ~key_q;
    assign key_fall = ~key_down & key_q;
    assign full     = (count == CW'(DEPTH));
    assign busy     = (state == StLoad) || (state == StSound) || (state == StGap);
    assign last     = (({1'b0, play_index} + CW'(1)) >= count);
    assign wr_entry = {rec_note, rec_oct, (dur == '0) ? DUR_W'(1) : dur};

    always_comb begin
        go_clear  = 1'b0;
        go_load   = 1'b0;
        go_rec    = 1'b0;
        rec_end   = 1'b0;
        stop      = 1'b0;
        sound_end = 1'b0;
        gap_end   = 1'b0;
        unique case (state)
            StIdle: begin
                if (clear) begin
                    go_clear = 1'b1;
                end else if (play_start && count != '0) begin
                    go_load = 1'b1;
                end else if (key_rise && record_en && !full) begin
                    go_rec = 1'b1;
                end
            end
            StRec:   rec_end = key_fall;
            StLoad:  stop = play_stop;
            StSound: begin
                stop      = play_stop;
                sound_end = !play_stop && tick && (dur == DUR_W'(1));
            end
            StGap: begin
                stop    = play_stop;
                gap_end = !play_stop && tick && (dur == DUR_W'(1));
            end
            default: ;
        endcase
    end

    // Restarting the prescaler on every state change makes each duration exact.
    assign state_chg = go_load | go_rec | rec_end | stop | sound_end | gap_end |
                       (state == StLoad);

    // Address the next entry one cycle early so the read lands during LOAD.
    assign rd_addr = (gap_end && !last) ? play_index + AW'(1) : play_index;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (state_chg),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (rec_end) begin
            mem[count[AW-1:0]] <= wr_entry;
        end
        rd_q <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= StIdle;
            key_q      <= 1'b0;
            rec_note   <= '0;
            rec_oct    <= '0;
            dur        <= '0;
            note_out   <= '0;
            octave_out <= '0;
            sound_on   <= 1'b0;
            count      <= '0;
            play_index <= '0;
            done       <= 1'b0;
        end else begin
            key_q <= key_down;
            done  <= 1'b0;
            unique case (state)
                StIdle: begin
                    note_out   <= note_in;
                    octave_out <= octave_in;
                    sound_on   <= key_down;
                    if (go_clear) begin
                        count <= '0;
                    end else if (go_load) begin
                        state    <= StLoad;
                        sound_on <= 1'b0;
                    end else if (go_rec) begin
                        state    <= StRec;
                        rec_note <= note_in;
                        rec_oct  <= octave_in;
                        dur      <= '0;
                    end
                end
                StRec: begin
                    note_out   <= note_in;
                    octave_out <= octave_in;
                    sound_on   <= key_down;
                    if (rec_end) begin
                        state <= StIdle;
                        count <= count + CW'(1);
                    end else if (tick && dur != '1) begin
                        dur <= dur + DUR_W'(1);
                    end
                end
                StLoad: begin
                    if (stop) begin
                        state      <= StIdle;
                        sound_on   <= 1'b0;
                        play_index <= '0;
                    end else begin
                        state      <= StSound;
                        note_out   <= rd_q[EW-1 -: NOTE_W];
                        octave_out <= rd_q[DUR_W +: OCT_W];
                        dur        <= rd_q[DUR_W-1:0];
                        sound_on   <= 1'b1;
                    end
                end
                StSound: begin
                    if (stop) begin
                        state      <= StIdle;
                        sound_on   <= 1'b0;
                        play_index <= '0;
                    end else if (sound_end) begin
                        state    <= StGap;
                        sound_on <= 1'b0;
                        dur      <= DUR_W'(GAP_TICKS);
                    end else if (tick) begin
                        dur <= dur - DUR_W'(1);
                    end
                end
                StGap: begin
                    if (stop) begin
                        state      <= StIdle;
                        sound_on   <= 1'b0;
                        play_index <= '0;
                    end else if (gap_end) begin
                        if (last) begin
                            state      <= StIdle;
                            play_index <= '0;
                            done       <= 1'b1;
                        end else begin
                            state      <= StLoad;
                            play_index <= play_index + AW'(1);
                        end
                    end else if (tick) begin
                        dur <= dur - DUR_W'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: record, playback timing, full/clear, stop and reset cases.
module tb_note_sequencer;
    import music_pkg::*;

    localparam int unsigned DEPTH     = 4;
    localparam int unsigned DUR_W     = 16;
    localparam int unsigned TICK_DIV  = 4;
    localparam int unsigned GAP_TICKS = 1;
    localparam int unsigned AW        = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NOTE_W-1:0] note_in = '0;
    logic [OCT_W-1:0]  octave_in = '0;
    logic              key_down = 1'b0;
    logic              record_en = 1'b0;
    logic              play_start = 1'b0;
    logic              play_stop = 1'b0;
    logic              clear = 1'b0;
    logic [NOTE_W-1:0] note_out;
    logic [OCT_W-1:0]  octave_out;
    logic              sound_on;
    logic              busy;
    logic [AW:0]       count;
    logic [AW-1:0]     play_index;
    logic              full;
    logic              done;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    note_sequencer #(
        .DEPTH     (DEPTH),
        .DUR_W     (DUR_W),
        .TICK_DIV  (TICK_DIV),
        .GAP_TICKS (GAP_TICKS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .note_in    (note_in),
        .octave_in  (octave_in),
        .key_down   (key_down),
        .record_en  (record_en),
        .play_start (play_start),
        .play_stop  (play_stop),
        .clear      (clear),
        .note_out   (note_out),
        .octave_out (octave_out),
        .sound_on   (sound_on),
        .busy       (busy),
        .count      (count),
        .play_index (play_index),
        .full       (full),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Hold a key for c rising edges, then release and settle back in IDLE.
    task automatic press(input int n, input int o, input int c);
        note_in   = NOTE_W'(n);
        octave_in = OCT_W'(o);
        key_down  = 1'b1;
        repeat (c) cyc();
        key_down = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic measure_high(output int n);
        n = 0;
        while (sound_on === 1'b1 && n < 200) begin
            n++;
            cyc();
        end
    endtask

    task automatic measure_low(output int n);
        n = 0;
        while (sound_on === 1'b0 && n < 200) begin
            n++;
            cyc();
        end
    endtask

    task automatic start_play();
        play_start = 1'b1;
        cyc();
        play_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int hi, lo, d0;
        int n3[3] = '{3, 7, 12};
        int o3[3] = '{0, 1, 3};
        int t3[3] = '{2, 1, 3};

        cyc();
        cyc();
        check_eq("rst_sound", 32'(sound_on), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_count", 32'(count), 0);
        check_eq("rst_full", 32'(full), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_note", 32'({note_out, octave_out}), 0);
        reset = 1'b1;
        cyc();

        // Passthrough latency: one register
        note_in = 4'd10; octave_in = 2'd3; key_down = 1'b1;
        cyc();
        check_eq("pass_note", 32'(note_out), 10);
        check_eq("pass_oct", 32'(octave_out), 3);
        check_eq("pass_sound", 32'(sound_on), 1);
        key_down = 1'b0;
        cyc();
        cyc();
        check_eq("norec_count", 32'(count), 0);

        // Record: 13-cycle hold -> dur 3, 2-cycle hold -> dur 1
        record_en = 1'b1;
        press(5, 2, 13);
        check_eq("rec1_count", 32'(count), 1);
        press(9, 1, 2);
        check_eq("rec2_count", 32'(count), 2);
        start_play();
        check_eq("t2_load_busy", 32'(busy), 1);
        check_eq("t2_load_sound", 32'(sound_on), 0);
        cyc();
        check_eq("t2_s0_sound", 32'(sound_on), 1);
        check_eq("t2_s0_note", 32'(note_out), 5);
        check_eq("t2_s0_oct", 32'(octave_out), 2);
        measure_high(hi);
        check_eq("t2_s0_len", 32'(hi), 12);
        measure_low(lo);
        check_eq("t2_gap_len", 32'(lo), 5);
        check_eq("t2_s1_note", 32'(note_out), 9);
        check_eq("t2_s1_idx", 32'(play_index), 1);
        measure_high(hi);
        check_eq("t2_s1_len", 32'(hi), 4);
        repeat (3) cyc();
        check_eq("t2_lastgap_busy", 32'(busy), 1);
        cyc();
        check_eq("t2_done", 32'(done), 1);
        check_eq("t2_idle_busy", 32'(busy), 0);
        check_eq("t2_idle_idx", 32'(play_index), 0);
        cyc();
        check_eq("t2_done_pulse", 32'(done), 0);

        // Three notes, full playback timing
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        check_eq("t3_clear", 32'(count), 0);
        press(3, 0, 9);
        press(7, 1, 5);
        press(12, 3, 13);
        check_eq("t3_count", 32'(count), 3);
        d0 = done_cnt;
        start_play();
        cyc();
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("t3_s%0d_note", k), 32'(note_out), n3[k]);
            check_eq($sformatf("t3_s%0d_oct", k), 32'(octave_out), o3[k]);
            check_eq($sformatf("t3_s%0d_idx", k), 32'(play_index), k);
            measure_high(hi);
            check_eq($sformatf("t3_s%0d_len", k), 32'(hi), t3[k] * TICK_DIV);
            if (k < 2) begin
                measure_low(lo);
                check_eq($sformatf("t3_g%0d_len", k), 32'(lo), GAP_TICKS * TICK_DIV + 1);
            end
        end
        repeat (GAP_TICKS * TICK_DIV + 10) cyc();
        check_eq("t3_done_once", 32'(done_cnt - d0), 1);

        // Asynchronous reset mid-SOUND
        start_play();
        cyc();
        cyc();
        #1 reset = 1'b0;
        #1;
        check_eq("t1_rst_sound", 32'(sound_on), 0);
        check_eq("t1_rst_busy", 32'(busy), 0);
        check_eq("t1_rst_count", 32'(count), 0);
        check_eq("t1_rst_note", 32'(note_out), 0);
        check_eq("t1_rst_idx", 32'(play_index), 0);
        reset = 1'b1;
        cyc();
        check_eq("t1_post_count", 32'(count), 0);
        check_eq("t1_post_busy", 32'(busy), 0);

        // Fill, reject fifth press, clear
        for (int k = 0; k < 4; k++) press(k + 1, 1, 5);
        check_eq("t4_count", 32'(count), 4);
        check_eq("t4_full", 32'(full), 1);
        note_in = 4'd6; key_down = 1'b1;
        cyc();
        cyc();
        check_eq("t4_full_pass", 32'(sound_on), 1);
        key_down = 1'b0;
        cyc();
        cyc();
        check_eq("t4_full_keep", 32'(count), 4);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        check_eq("t4_clear_count", 32'(count), 0);
        check_eq("t4_clear_full", 32'(full), 0);

        // play_stop during second SOUND
        press(2, 1, 5);
        press(4, 2, 9);
        d0 = done_cnt;
        start_play();
        cyc();
        measure_high(hi);
        check_eq("t5_s0_len", 32'(hi), 4);
        measure_low(lo);
        check_eq("t5_s1_idx", 32'(play_index), 1);
        cyc();
        cyc();
        play_stop = 1'b1;
        cyc();
        play_stop = 1'b0;
        check_eq("t5_stop_sound", 32'(sound_on), 0);
        check_eq("t5_stop_busy", 32'(busy), 0);
        check_eq("t5_stop_idx", 32'(play_index), 0);
        repeat (20) cyc();
        check_eq("t5_no_done", 32'(done_cnt - d0), 0);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        start_play();
        check_eq("t5_empty_play", 32'(busy), 0);

        // clear beats play_start; play_start ignored during REC
        press(1, 1, 5);
        check_eq("t6_pre_count", 32'(count), 1);
        clear = 1'b1;
        play_start = 1'b1;
        cyc();
        clear = 1'b0;
        play_start = 1'b0;
        check_eq("t6_clr_count", 32'(count), 0);
        check_eq("t6_clr_busy", 32'(busy), 0);
        cyc();
        check_eq("t6_clr_busy2", 32'(busy), 0);
        note_in = 4'd11; octave_in = 2'd2; key_down = 1'b1;
        cyc();
        cyc();
        play_start = 1'b1;
        cyc();
        play_start = 1'b0;
        check_eq("t6_rec_busy", 32'(busy), 0);
        repeat (10) cyc();
        key_down = 1'b0;
        cyc();
        cyc();
        check_eq("t6_rec_count", 32'(count), 1);
        start_play();
        cyc();
        check_eq("t6_play_note", 32'(note_out), 11);
        measure_high(hi);
        check_eq("t6_play_len", 32'(hi), 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Records live keyboard notes (note, octave, hold duration) into a small on-chip buffer and plays them back with their recorded timing. Sits between `convert_keyboard_input` and the note/frequency `datapath`. In idle and record it passes live notes through; in playback it drives the datapath from the buffer, so the live keyboard and the recorded song share one tone path.

## Interface
- `DEPTH`, 16: buffer entries (power of two).
- `DUR_W`, 16: duration field width, in ticks.
- `TICK_DIV`, 500000: clk cycles per tick (10 ms at 50 MHz).
- `GAP_TICKS`, 2: silent ticks between played notes.

Ports:
- `clk` in 1: system clock (CLOCK_50).
- `reset` in 1: asynchronous, active-low reset (driven from KEY[0]).
- `note_in` in 4: live note code.
- `octave_in` in 2: live octave.
- `key_down` in 1: level, high while a note key is held.
- `record_en` in 1: level; when high, key presses made in IDLE are stored.
- `play_start` in 1: one-cycle pulse that starts playback.
- `play_stop` in 1: one-cycle pulse that aborts playback.
- `clear` in 1: one-cycle pulse that empties the buffer.
- `note_out` out 4: note to the datapath (registered).
- `octave_out` out 2: octave to the datapath (registered).
- `sound_on` out 1: tone enable (registered).
- `busy` out 1: high in LOAD, SOUND and GAP.
- `count` out $clog2(DEPTH)+1: number of stored entries.
- `play_index` out $clog2(DEPTH): entry currently being played.
- `full` out 1: `count == DEPTH`.
- `done` out 1: one-cycle pulse when playback completes normally.

## Operation
- Reset values: state IDLE; `note_out`, `octave_out`, `sound_on`, `busy`, `count`, `play_index`, `full`, `done` all 0. Buffer contents are don't-care.
- States and transitions:
  - IDLE → REC on a `key_down` rising edge when `record_en`=1 and `!full`.
  - IDLE → LOAD on `play_start` when `count > 0`.
  - REC → IDLE on a `key_down` falling edge.
  - LOAD → SOUND after 1 cycle.
  - SOUND → GAP after the entry's duration elapses.
  - GAP → LOAD when `play_index+1 < count`; otherwise GAP → IDLE.
- Key edges are detected against a registered copy of `key_down`.
- IDLE and REC (passthrough): `note_out`/`octave_out` follow `note_in`/`octave_in` and `sound_on` follows `key_down`, each with one register of delay.
- REC:
  - On entry, latch `note_in`/`octave_in` and set the duration counter to 0.
  - Each tick increments the duration counter, saturating at 2^DUR_W−1.
  - On the falling edge, write {note, octave, max(dur,1)} at index `count`, increment `count`, return to IDLE.
- LOAD: read entry `play_index`; drive `note_out`/`octave_out` from it.
- SOUND: `sound_on`=1 for exactly dur×TICK_DIV cycles.
- GAP: `sound_on`=0 for GAP_TICKS×TICK_DIV cycles, then increment `play_index`.
- Last entry: GAP → IDLE with `done`=1 for one cycle and `play_index` returned to 0.
- Tick prescaler: cleared on every state change, so every duration is exact.
- IDLE priority when events coincide:
  1. `clear`: sets `count`=0; `full` drops next cycle.
  2. `play_start`.
  3. `key_down` rising edge.
- Ignored inputs:
  - `play_start` with `count`=0.
  - `play_start` and `clear` outside IDLE.
  - Key rising edges while `full`; passthrough still sounds.
- `play_stop` in LOAD, SOUND or GAP has priority over everything. Next cycle: IDLE, `sound_on`=0, `play_index`=0, no `done`. `play_stop` in IDLE or REC is ignored.
- Recording while `record_en`=0 stores nothing. Dropping `record_en` mid-REC does not abort the capture.
- Asynchronous reset mid-operation forces the reset values immediately; any partially captured note is discarded.

## Timing
- `play_start` sampled in cycle N: LOAD in N+1. SOUND in N+2, with `sound_on`=1 and entry 0 on `note_out`/`octave_out`.
- Entry k, duration d: SOUND lasts d×TICK_DIV cycles, GAP lasts GAP_TICKS×TICK_DIV cycles, then LOAD for entry k+1 (1 cycle).
- `done` asserts in the first IDLE cycle after the last GAP.
- Passthrough latency: 1 cycle, input to output.
- Buffer write occurs in the cycle after the falling edge is detected; `count` updates in that same cycle.
- Buffer read latency: 1 cycle; LOAD absorbs it, which suits synchronous M10K inference.

## Structure
- Shared package `music_pkg`:
  - State enum (IDLE, REC, LOAD, SOUND, GAP).
  - Widths: `NOTE_W`=4, `OCT_W`=2.
  - Entry width `NOTE_W+OCT_W+DUR_W`.
- Sub-module `tick_prescaler`: counter 0..TICK_DIV−1 with a synchronous clear input and a one-cycle `tick` output.
- Buffer is an inferred register/RAM array indexed by `count` for writes and `play_index` for reads.

## Test plan
Bench parameters: TICK_DIV=4, GAP_TICKS=1, DEPTH=4.

1. Reset mid-SOUND → all outputs 0 immediately; `count`=0 after release.
2. `record_en`=1; hold note 5, octave 2, for 13 cycles → `count`=1, stored dur=3. Hold a second note for 2 cycles → stored dur=1 (minimum).
3. Record 3 notes with durs 2, 1, 3; pulse `play_start` at cycle N:
   - `sound_on` high N+2..N+9 with note 0.
   - Low for 4 cycles.
   - LOAD for 1 cycle, then note 1 sounds for 4 cycles, and so on.
   - `done` pulses exactly once.
4. Record 4 notes → `full`=1. A fifth press is not stored and `count` stays 4. `clear` → `count`=0 and `full`=0 next cycle.
5. `play_stop` during the second SOUND → `sound_on`=0 and `busy`=0 next cycle, `done` never asserts. `play_start` with `count`=0 → stays IDLE.
6. `clear` and `play_start` in the same IDLE cycle → buffer emptied, no playback. `play_start` pulsed during REC → ignored; the capture completes normally.
